// File: rtl/cb_dequantizer_if.sv
// Valid/ready bundle carrying quantized Cb coefficients into the dequantizer
// and dequantized coefficients on to the inverse-DCT stage.
`timescale 1ns/1ps
interface cb_dequantizer_if #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_coef;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_coef;
  logic [5:0]       out_idx;
  logic             out_last;
  logic             out_sat;

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_coef, out_idx, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_coef, out_idx, out_last, out_sat
  );
endinterface

// File: rtl/cb_dequantizer.sv
// Two-stage Cb dequantizer: out = sat(coef * QT[idx]) in raster order, idx from a wrapping counter.
// Define CB_DEQ_QTABLE_LOAD_EN to make the quantization table writable at run time.
`timescale 1ns/1ps
module cb_dequantizer #(
  parameter int IN_W  = 11,
  parameter int OUT_W = 12,
  parameter int QT_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CB_DEQ_QTABLE_LOAD_EN
  input  logic            qt_wr_en,
  input  logic [5:0]      qt_wr_addr,
  input  logic [QT_W-1:0] qt_wr_data,
`endif
  cb_dequantizer_if.slave bus
);
  localparam int PROD_W   = IN_W + QT_W;
  localparam int SAT_HI_I = 2**(OUT_W-1) - 1;
  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(SAT_HI_I);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-SAT_HI_I - 1);

  // Same values as Q_MATRIX in quantizer_constant.svh (standard JPEG chrominance table).
  localparam int Q_MATRIX [8][8] = '{
    '{17, 18, 24, 47, 99, 99, 99, 99},
    '{18, 21, 26, 66, 99, 99, 99, 99},
    '{24, 26, 56, 99, 99, 99, 99, 99},
    '{47, 66, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99},
    '{99, 99, 99, 99, 99, 99, 99, 99}
  };

  function automatic logic [QT_W-1:0] default_qt(input logic [5:0] idx);
    return QT_W'(Q_MATRIX[idx[5:3]][idx[2:0]]);
  endfunction

  logic                     w_stall;
  logic                     w_in_fire;
  logic [5:0]               r_idx;
  logic [QT_W-1:0]          w_qt;

  logic                     r_s1_valid;
  logic signed [IN_W-1:0]   r_s1_coef;
  logic [QT_W-1:0]          r_s1_qt;
  logic [5:0]               r_s1_idx;
  logic                     r_s1_last;

  logic signed [PROD_W-1:0] w_prod;
  logic [OUT_W-1:0]         w_clamped;
  logic                     w_sat;

  logic                     r_s2_valid;
  logic [OUT_W-1:0]         r_s2_coef;
  logic [5:0]               r_s2_idx;
  logic                     r_s2_last;
  logic                     r_s2_sat;

  assign w_stall   = r_s2_valid && !bus.out_ready;
  assign w_in_fire = bus.in_valid && !w_stall;

`ifdef CB_DEQ_QTABLE_LOAD_EN
  logic [QT_W-1:0] r_qt [64];

  // A zero entry would give the matching quantizer a zero divisor, so it is stored as 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) r_qt[i] <= default_qt(6'(i));
    end else if (qt_wr_en) begin
      r_qt[qt_wr_addr] <= (qt_wr_data == '0) ? QT_W'(1) : qt_wr_data;
    end
  end

  assign w_qt = r_qt[r_idx];
`else
  assign w_qt = default_qt(r_idx);
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= bus.in_valid;
      r_s2_valid <= r_s1_valid;
      if (w_in_fire) r_idx <= r_idx + 6'd1;
    end
  end

  // NOTE: S1 payload is not reset; r_s1_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_coef <= $signed(bus.in_coef);
      r_s1_qt   <= w_qt;
      r_s1_idx  <= r_idx;
      r_s1_last <= (r_idx == 6'd63);
    end
  end

  assign w_prod = PROD_W'(r_s1_coef) * PROD_W'($signed({1'b0, r_s1_qt}));

  // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
  always_comb begin
    w_clamped = w_prod[OUT_W-1:0];
    w_sat     = 1'b0;
    if (w_prod > SAT_HI) begin
      w_clamped = SAT_HI[OUT_W-1:0];
      w_sat     = 1'b1;
    end else if (w_prod < SAT_LO) begin
      w_clamped = SAT_LO[OUT_W-1:0];
      w_sat     = 1'b1;
    end
  end

  // Output payload only moves on real data, so it stays put through bubbles and stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_coef <= '0;
      r_s2_idx  <= '0;
      r_s2_last <= 1'b0;
      r_s2_sat  <= 1'b0;
    end else if (!w_stall && r_s1_valid) begin
      r_s2_coef <= w_clamped;
      r_s2_idx  <= r_s1_idx;
      r_s2_last <= r_s1_last;
      r_s2_sat  <= w_sat;
    end
  end

  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_coef  = r_s2_coef;
  assign bus.out_idx   = r_s2_idx;
  assign bus.out_last  = r_s2_last;
  assign bus.out_sat   = r_s2_sat;
endmodule
